// File: rtl/float_acc_seq_if.sv
// rtl/float_acc_seq_if.sv - operand input stream and packet-sum output stream of float_acc_seq
interface float_acc_seq_if #(
    parameter int float_width = 16,
    parameter int cnt_width   = 8
);
    logic [float_width-1:0] in_data;
    logic                   in_last;
    logic                   in_valid;
    logic                   in_ready;
    logic [float_width-1:0] out_data;
    logic [cnt_width-1:0]   out_count;
    logic                   out_sat;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_count, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_count, out_sat, out_valid
    );
endinterface

// File: rtl/float_acc_seq.sv
// rtl/float_acc_seq.sv - FP16 packet reduction controller driving an external combinational adder
module float_acc_seq #(
    parameter int float_width    = 16,
    parameter int exponent_width = 5,
    parameter int mantissa_width = 10,
    parameter int cnt_width      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    output logic [float_width-1:0] add_a,
    output logic [float_width-1:0] add_b,
    input  logic [float_width-1:0] add_res,
    float_acc_seq_if.slave         s
);
    localparam logic [float_width-1:0] neg_zero =
        {1'b1, {(exponent_width + mantissa_width){1'b0}}};
    localparam logic [cnt_width-1:0] cnt_max = {cnt_width{1'b1}};

    typedef enum logic {ACCUM, OUT} state_t;

    state_t                 state_q, state_d;
    logic [float_width-1:0] acc;
    logic [cnt_width-1:0]   cnt;
    logic                   sat;
    logic [float_width-1:0] out_data_q;
    logic [cnt_width-1:0]   out_count_q;
    logic                   out_sat_q;

    logic                   take;
    logic                   deliver;
    logic [cnt_width-1:0]   cnt_inc;
    logic                   sat_nxt;

    // The adder treats only +0 as zero, so -0 is folded before it leaves the block.
    assign add_a = acc;
    assign add_b = (s.in_data == neg_zero) ? '0 : s.in_data;

    assign take    = (state_q == ACCUM) && s.in_valid && !flush;
    assign deliver = (state_q == OUT) && s.out_ready && !flush;
    assign cnt_inc = (cnt == cnt_max) ? cnt : cnt + 1'b1;
    assign sat_nxt = sat | (cnt == cnt_max);

    assign s.out_data  = out_data_q;
    assign s.out_count = out_count_q;
    assign s.out_sat   = out_sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        s.in_ready  = 1'b0;
        s.out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                s.in_ready = 1'b1;
                if (take && s.in_last) state_d = OUT;
            end
            OUT: begin
                s.out_valid = 1'b1;
                if (deliver) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
        if (flush) state_d = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            sat         <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (take) begin
            acc <= add_res;
            cnt <= cnt_inc;
            sat <= sat_nxt;
            if (s.in_last) begin
                out_data_q  <= add_res;
                out_count_q <= cnt_inc;
                out_sat_q   <= sat_nxt;
            end
        end else if (deliver) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end
    end
endmodule

// File: tb/tb_float_acc_seq.sv
// tb/tb_float_acc_seq.sv - directed bench for float_acc_seq with a real-valued FP16 adder model
module tb_float_acc_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] add_a, add_b, add_res;
    int          errors = 0;
    int          checks = 0;

    float_acc_seq_if #(.float_width(16), .cnt_width(8)) sif ();

    float_acc_seq #(
        .float_width(16), .exponent_width(5), .mantissa_width(10), .cnt_width(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .add_a(add_a), .add_b(add_b), .add_res(add_res),
        .s(sif.slave)
    );

    always #5 clk = ~clk;

    function automatic real pow2(int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
        else                  v = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(real v);
        logic        sg;
        int          e;
        real         a;
        logic [9:0]  m;
        logic [4:0]  eb;
        if (v == 0.0) return 16'h0000;
        sg = (v < 0.0);
        a  = sg ? -v : v;
        e  = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m  = 10'(int'((a - 1.0) * 1024.0));
        eb = 5'(e);
        return {sg, eb, m};
    endfunction

    always_comb add_res = r2h(h2r(add_a) + h2r(add_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        bit ok = 0;
        sif.in_data  = d;
        sif.in_last  = last;
        sif.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (sif.in_ready) ok = 1;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
    endtask

    task automatic finish_pkt(input string tag, input logic [15:0] d, input int c, input logic st);
        @(negedge clk);
        check({tag, "_valid"}, 32'(sif.out_valid), 32'd1);
        check({tag, "_data"},  32'(sif.out_data),  32'(d));
        check({tag, "_count"}, 32'(sif.out_count), 32'(c));
        check({tag, "_sat"},   32'(sif.out_sat),   32'(st));
        @(posedge clk); #1;
    endtask

    initial begin
        sif.in_data = '0; sif.in_last = 1'b0; sif.in_valid = 1'b0; sif.out_ready = 1'b1;
        #12;
        check("rst_in_ready",  32'(sif.in_ready),  32'd1);
        check("rst_out_valid", 32'(sif.out_valid), 32'd0);
        check("rst_out_data",  32'(sif.out_data),  32'd0);
        check("rst_out_count", 32'(sif.out_count), 32'd0);
        check("rst_add_a",     32'(add_a),         32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1 + 2 + 3 = 6, one OUT cycle then ready again
        send(16'h3C00, 0); send(16'h4000, 0); send(16'h4200, 1);
        @(negedge clk);
        check("p1_valid",    32'(sif.out_valid), 32'd1);
        check("p1_in_ready", 32'(sif.in_ready),  32'd0);
        check("p1_data",     32'(sif.out_data),  32'h4600);
        check("p1_count",    32'(sif.out_count), 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        check("p1_valid_drop", 32'(sif.out_valid), 32'd0);
        check("p1_ready_back", 32'(sif.in_ready),  32'd1);
        @(posedge clk); #1;

        // single element with back-pressure
        sif.out_ready = 1'b0;
        send(16'h3C00, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid",    32'(sif.out_valid), 32'd1);
            check("bp_data",     32'(sif.out_data),  32'h3C00);
            check("bp_in_ready", 32'(sif.in_ready),  32'd0);
            @(posedge clk); #1;
        end
        sif.out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept", 32'(sif.out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_after_valid", 32'(sif.out_valid), 32'd0);
        check("bp_after_acc",   32'(add_a),         32'd0);
        @(posedge clk); #1;

        send(16'h4000, 0); send(16'hC000, 1);
        finish_pkt("cancel", 16'h0000, 2, 0);

        sif.in_data = 16'h8000; #1;
        check("negzero_add_b", 32'(add_b), 32'd0);
        send(16'h8000, 0); send(16'h3C00, 1);
        finish_pkt("negzero", 16'h3C00, 2, 0);

        // flush drops the partial sum and ignores the element on the flush cycle
        send(16'h3C00, 0); send(16'h3C00, 0);
        flush = 1'b1; sif.in_valid = 1'b1; sif.in_data = 16'h3C00;
        @(posedge clk); #1;
        flush = 1'b0; sif.in_valid = 1'b0;
        @(negedge clk);
        check("flush_acc", 32'(add_a), 32'd0);
        send(16'h4000, 1);
        finish_pkt("flush", 16'h4000, 1, 0);

        for (int i = 0; i < 300; i++) send(16'h0000, 0);
        send(16'h0000, 1);
        finish_pkt("sat", 16'h0000, 255, 1);

        // asynchronous reset while a result is pending
        sif.out_ready = 1'b0;
        send(16'h4000, 0); send(16'h3C00, 1);
        @(negedge clk);
        check("prerst_valid", 32'(sif.out_valid), 32'd1);
        check("prerst_data",  32'(sif.out_data),  32'h4200);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(sif.out_valid), 32'd0);
        check("arst_count", 32'(sif.out_count), 32'd0);
        check("arst_data",  32'(sif.out_data),  32'd0);
        check("arst_acc",   32'(add_a),         32'd0);
        check("arst_ready", 32'(sif.in_ready),  32'd1);
        @(negedge clk); rst_n = 1'b1; sif.out_ready = 1'b1;
        @(posedge clk); #1;
        send(16'h4200, 1);
        finish_pkt("post_rst", 16'h4200, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
